// File: rtl/scan_pkg.sv
// Shared types and frame geometry for the raster pixel scanner.
package scan_pkg;

    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // One pixel in flight between address issue and the vga_adapter write.
    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pixel_t;

endpackage

// File: rtl/scan_delay_line.sv
// Fixed-latency shift register of pixel_t. Shifts every clock and is never
// stalled, so a pixel entering at cycle t leaves at cycle t+LAT.
module scan_delay_line
    import scan_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  pixel_t din,
    output pixel_t dout
);

    pixel_t stage_q [LAT];
    pixel_t stage_d [LAT];

    // Next contents: new pixel enters stage 0, every other stage takes its predecessor.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared immediately on reset so no stale pixel is plotted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[LAT-1];

endmodule

// File: rtl/pixel_scanner.sv
// Raster address generator feeding the colour renderer and the vga_adapter.
// x/y go to the renderer; plot/plot_x/plot_y come out LAT clocks later so they
// line up with the renderer's colour. Optional macro SCAN_WINDOW_EN restricts
// the scan to an inclusive rectangle latched on entry to SCAN.
//
// Timing contract: a pixel is issued in any SCAN cycle with pause=0 (issue_valid);
// the coordinates of an issue at cycle t appear on plot_x/plot_y with plot=1 at
// cycle t+LAT. There is no back-pressure from the renderer or vga_adapter.
module pixel_scanner
    import scan_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              continuous,
    input  logic              pause,
`ifdef SCAN_WINDOW_EN
    input  logic [X_W-1:0]    win_x0,
    input  logic [X_W-1:0]    win_x1,
    input  logic [Y_W-1:0]    win_y0,
    input  logic [Y_W-1:0]    win_y1,
`endif
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [X_W-1:0]    plot_x,
    output logic [Y_W-1:0]    plot_y,
    output logic              plot,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output scan_state_t       state_dbg
);

    scan_state_t    state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [2:0]     flush_cnt_q, flush_cnt_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           issue_valid;
    logic           enter_scan;

    // Scan bounds and first coordinate; constant full frame unless windowed.
    logic [X_W-1:0] x_lo, x_hi, entry_x;
    logic [Y_W-1:0] y_hi, entry_y;
    logic           win_empty;

`ifdef SCAN_WINDOW_EN
    logic [X_W-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
    logic [Y_W-1:0] y_hi_q, y_hi_d;
    logic           empty_q, empty_d;

    // Window bounds are captured only when a scan begins, so mid-frame changes are ignored.
    always_comb begin
        x_lo_d  = x_lo_q;
        x_hi_d  = x_hi_q;
        y_hi_d  = y_hi_q;
        empty_d = empty_q;
        if (enter_scan) begin
            x_lo_d  = win_x0;
            x_hi_d  = win_x1;
            y_hi_d  = win_y1;
            empty_d = (win_x0 > win_x1) || (win_y0 > win_y1);
        end
    end

    // Window bound registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_lo_q  <= '0;
            x_hi_q  <= X_LAST;
            y_hi_q  <= Y_LAST;
            empty_q <= 1'b0;
        end else begin
            x_lo_q  <= x_lo_d;
            x_hi_q  <= x_hi_d;
            y_hi_q  <= y_hi_d;
            empty_q <= empty_d;
        end
    end

    assign x_lo      = x_lo_q;
    assign x_hi      = x_hi_q;
    assign y_hi      = y_hi_q;
    assign win_empty = empty_q;
    assign entry_x   = win_x0;
    assign entry_y   = win_y0;
`else
    assign x_lo      = '0;
    assign x_hi      = X_LAST;
    assign y_hi      = Y_LAST;
    assign win_empty = 1'b0;
    assign entry_x   = '0;
    assign entry_y   = '0;
`endif

    // Next-state, raster stepping, flush timing and frame counting.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        flush_cnt_d = flush_cnt_q;
        frame_cnt_d = frame_cnt_q;
        issue_valid = 1'b0;
        enter_scan  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    enter_scan = 1'b1;
                end
            end
            SCAN: begin
                if (win_empty) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (!pause) begin
                    issue_valid = 1'b1;
                    if (x_q == x_hi) begin
                        if (y_q == y_hi) begin
                            // Last pixel: hold x/y, let the delay line drain.
                            state_d     = FLUSH;
                            flush_cnt_d = '0;
                        end else begin
                            x_d = x_lo;
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 3'(LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            DONE: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                if (continuous) begin
                    state_d    = SCAN;
                    enter_scan = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_scan) begin
            x_d = entry_x;
            y_d = entry_y;
        end
    end

    // State, coordinate and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            flush_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            flush_cnt_q <= flush_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    pixel_t pix_in, pix_out;

    assign pix_in = '{valid: issue_valid, x: x_q, y: y_q};

    scan_delay_line #(.LAT(LAT)) u_delay (
        .clk   (clk),
        .rst_n (resetn),
        .din   (pix_in),
        .dout  (pix_out)
    );

    assign x          = x_q;
    assign y          = y_q;
    assign plot       = pix_out.valid;
    assign plot_x     = pix_out.x;
    assign plot_y     = pix_out.y;
    assign busy       = (state_q == SCAN) || (state_q == FLUSH);
    assign frame_done = (state_q == DONE);
    assign frame_cnt  = frame_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pixel_scanner.sv
// Bench for pixel_scanner: instance A (LAT=1) and instance B (LAT=3, continuous).
module tb_pixel_scanner;
    import scan_pkg::*;

    localparam int PW = X_W + Y_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks_n = 0;
    int fails_n  = 0;

    // ---------------- instance A signals ----------------
    logic resetn_a = 1'b0, start_a = 1'b0, cont_a = 1'b0, pause_a = 1'b0;
    logic [X_W-1:0] x_a, plot_x_a;
    logic [Y_W-1:0] y_a, plot_y_a;
    logic plot_a, busy_a, frame_done_a;
    logic [7:0] frame_cnt_a;
    scan_state_t state_a;
    int wx0 = 0, wx1 = H_RES - 1, wy0 = 0, wy1 = V_RES - 1;

    // ---------------- instance B signals ----------------
    logic resetn_b = 1'b0, start_b = 1'b0, cont_b = 1'b0, pause_b = 1'b0;
    logic [X_W-1:0] x_b, plot_x_b;
    logic [Y_W-1:0] y_b, plot_y_b;
    logic plot_b, busy_b, frame_done_b;
    logic [7:0] frame_cnt_b;
    scan_state_t state_b;

    pixel_scanner #(.LAT(1)) dut_a (
        .clk(clk), .resetn(resetn_a), .start(start_a), .continuous(cont_a), .pause(pause_a),
`ifdef SCAN_WINDOW_EN
        .win_x0(X_W'(wx0)), .win_x1(X_W'(wx1)), .win_y0(Y_W'(wy0)), .win_y1(Y_W'(wy1)),
`endif
        .x(x_a), .y(y_a), .plot_x(plot_x_a), .plot_y(plot_y_a), .plot(plot_a),
        .busy(busy_a), .frame_done(frame_done_a), .frame_cnt(frame_cnt_a), .state_dbg(state_a)
    );

    pixel_scanner #(.LAT(3)) dut_b (
        .clk(clk), .resetn(resetn_b), .start(start_b), .continuous(cont_b), .pause(pause_b),
`ifdef SCAN_WINDOW_EN
        .win_x0(X_W'(0)), .win_x1(X_W'(H_RES - 1)), .win_y0(Y_W'(0)), .win_y1(Y_W'(V_RES - 1)),
`endif
        .x(x_b), .y(y_b), .plot_x(plot_x_b), .plot_y(plot_y_b), .plot(plot_b),
        .busy(busy_b), .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .state_dbg(state_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fails_n++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xy(input int px, input int py);
        return 32'((px << Y_W) | py);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // ---------------- scoreboard A: expected raster in exp_q_a ----------------
    logic [PW-1:0] exp_q_a[$];
    int  plot_cnt_a = 0, seq_err_a = 0, gap_a = 0, done_cnt_a = 0, exp_total_a = 0;
    logic [31:0] first_a = '0, last_a = '0;
    bit  loaded_a = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn_a) begin
                if (!loaded_a) begin
                    exp_q_a.delete();
                    for (int yy = wy0; yy <= wy1; yy++)
                        for (int xx = wx0; xx <= wx1; xx++)
                            exp_q_a.push_back({X_W'(xx), Y_W'(yy)});
                    exp_total_a = exp_q_a.size();
                    loaded_a = 1;
                end
                plot_cnt_a = 0; seq_err_a = 0; gap_a = 0; done_cnt_a = 0;
            end else begin
                loaded_a = 0;
                if (frame_done_a) done_cnt_a++;
                if (plot_a) begin
                    if (plot_cnt_a == 0) first_a = 32'({plot_x_a, plot_y_a});
                    last_a = 32'({plot_x_a, plot_y_a});
                    if (exp_q_a.size() == 0) seq_err_a++;
                    else if (exp_q_a.pop_front() != {plot_x_a, plot_y_a}) seq_err_a++;
                    plot_cnt_a++;
                end else if (plot_cnt_a > 0 && plot_cnt_a < exp_total_a) begin
                    gap_a++;
                end
            end
        end
    end

    // ---------------- scoreboard B: frame plus start of next frame ----------------
    logic [PW-1:0] exp_q_b[$];
    int  plot_cnt_b = 0, seq_err_b = 0, done_cnt_b = 0, reiss_seen_b = 0;
    logic [31:0] reiss_b = '0;
    bit  loaded_b = 0, prev_done_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn_b) begin
                if (!loaded_b) begin
                    exp_q_b.delete();
                    for (int yy = 0; yy < V_RES; yy++)
                        for (int xx = 0; xx < H_RES; xx++)
                            exp_q_b.push_back({X_W'(xx), Y_W'(yy)});
                    for (int k = 0; k < 2000; k++)
                        exp_q_b.push_back({X_W'(k % H_RES), Y_W'(k / H_RES)});
                    loaded_b = 1;
                end
                plot_cnt_b = 0; seq_err_b = 0; done_cnt_b = 0; prev_done_b = 0;
            end else begin
                loaded_b = 0;
                if (prev_done_b) begin
                    reiss_b = 32'({busy_b, x_b, y_b});
                    reiss_seen_b++;
                end
                prev_done_b = frame_done_b;
                if (frame_done_b) done_cnt_b++;
                if (plot_b) begin
                    if (exp_q_b.size() == 0) seq_err_b++;
                    else if (exp_q_b.pop_front() != {plot_x_b, plot_y_b}) seq_err_b++;
                    plot_cnt_b++;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        int bad;

        repeat (3) tick();
        samp();
        check_eq("rst_a_xy",   32'({x_a, y_a}), 32'd0);
        check_eq("rst_a_plot", 32'({plot_a, plot_x_a, plot_y_a}), 32'd0);
        check_eq("rst_a_flags", 32'({busy_a, frame_done_a, frame_cnt_a}), 32'd0);
        check_eq("rst_a_state", 32'(state_a), 32'(IDLE));

        tick();
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        tick();
        start_a = 1'b1; start_b = 1'b1; cont_b = 1'b1;        // cycle 0
        tick();
        start_a = 1'b0; start_b = 1'b0;                       // cycle 1
        samp();
        check_eq("c1_a_xy",   32'({x_a, y_a}), xy(0, 0));
        check_eq("c1_a_busy", 32'(busy_a), 32'd1);
        check_eq("c1_a_plot", 32'(plot_a), 32'd0);
        tick();                                               // cycle 2
        samp();
        check_eq("c2_a_plot", 32'(plot_a), 32'd1);
        check_eq("c2_a_pxy",  32'({plot_x_a, plot_y_a}), xy(0, 0));
        check_eq("c2_b_plot", 32'(plot_b), 32'd0);
        tick(); tick();                                       // cycle 4
        samp();
        check_eq("c4_b_plot", 32'(plot_b), 32'd1);
        check_eq("c4_b_pxy",  32'({plot_x_b, plot_y_b}), xy(0, 0));
        tick(); tick();                                       // cycle 6
        pause_a = 1'b1;
        repeat (10) tick();                                   // cycle 16
        pause_a = 1'b0;
        samp();
        check_eq("c16_a_bubble", 32'(plot_a), 32'd0);
        tick();                                               // cycle 17
        samp();
        check_eq("c17_a_plot", 32'(plot_a), 32'd1);
        check_eq("c17_a_pxy",  32'({plot_x_a, plot_y_a}), xy(5, 0));

        repeat (100) tick();
        start_a = 1'b1;                                       // ignored while busy
        tick();
        start_a = 1'b0;

        seen = 0;
        for (int i = 0; i < 80000; i++) begin
            samp();
            if (frame_done_a) begin seen = 1; break; end
        end
        check_eq("a_done_seen", 32'(seen), 32'd1);
        tick();
        samp();
        check_eq("a_end_state", 32'(state_a), 32'(IDLE));
        check_eq("a_end_busy",  32'(busy_a), 32'd0);
        check_eq("a_frame_cnt", 32'(frame_cnt_a), 32'd1);
        check_eq("a_plots",     32'(plot_cnt_a), 32'd76800);
        check_eq("a_last",      last_a, xy(319, 239));
        check_eq("a_seq_err",   32'(seq_err_a), 32'd0);
        check_eq("a_gap",       32'(gap_a), 32'd10);
        check_eq("a_done_cnt",  32'(done_cnt_a), 32'd1);

        check_eq("b_done_cnt",  32'(done_cnt_b), 32'd1);
        check_eq("b_reissue",   reiss_b, 32'h0002_0000);
        check_eq("b_reiss_n",   32'(reiss_seen_b), 32'd1);
        check_eq("b_frame_cnt", 32'(frame_cnt_b), 32'd1);

        // Reset instance B at pixel 1000 of its second frame.
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            samp();
            if (x_b == X_W'(40) && y_b == Y_W'(3)) begin seen = 1; break; end
        end
        check_eq("b_px1000_seen", 32'(seen), 32'd1);
        check_eq("b_seq_err",   32'(seq_err_b), 32'd0);
        check_eq("b_plots_pre", 32'(plot_cnt_b > 76800), 32'd1);
        #2;
        resetn_b = 1'b0;
        #1;
        check_eq("b_rst_xy",    32'({x_b, y_b}), 32'd0);
        check_eq("b_rst_plot",  32'({plot_b, plot_x_b, plot_y_b}), 32'd0);
        check_eq("b_rst_flags", 32'({busy_b, frame_done_b, frame_cnt_b}), 32'd0);
        check_eq("b_rst_state", 32'(state_b), 32'(IDLE));
        tick(); tick();
        resetn_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            samp();
            if (plot_b || busy_b) bad++;
        end
        check_eq("b_quiet_after_rst", 32'(bad), 32'd0);

`ifdef SCAN_WINDOW_EN
        wx0 = 112; wx1 = 207; wy0 = 108; wy1 = 131;
        tick();
        resetn_a = 1'b0;
        tick(); tick();
        resetn_a = 1'b1;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            samp();
            if (frame_done_a) begin seen = 1; break; end
        end
        check_eq("w_done_seen", 32'(seen), 32'd1);
        tick();
        samp();
        check_eq("w_plots",    32'(plot_cnt_a), 32'd2304);
        check_eq("w_first",    first_a, xy(112, 108));
        check_eq("w_last",     last_a, xy(207, 131));
        check_eq("w_seq_err",  32'(seq_err_a), 32'd0);
        check_eq("w_done_cnt", 32'(done_cnt_a), 32'd1);
        check_eq("w_busy",     32'(busy_a), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
